pc_ctrl: RTL and testbench

// - Sequences the PC register in bru and the front of the pipeline. Issues fetch requests, accepts fetch responses,
//   and drives bru.i_pcwen plus IF/ID and ID/EX write-enables and flushes.
// - Applies the redirect from bru (o_ifid_bubble) and discards stale in-flight fetches.
// - Detects load-use hazards, counts stall cycles and flags a fetch timeout.

---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/pc_ctrl_if.sv | 29 ++
 rtl/pc_ctrl_hazard_det.sv | 27 ++
 rtl/pc_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_ctrl_pkg
// Brief   : Shared types and defaults for the PC / front-end sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    // Default register-index width used by the core
    localparam int REG_AW_DEF = 5;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } pc_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_ctrl_if
// Brief   : Fetch request/response handshake between pc_ctrl and the IFU.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_ctrl_if;
    logic req_valid;
    logic req_ready;
    logic rsp_valid;
    logic rsp_ready;

    // Sequencer side
    modport master (
        output req_valid,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid
    );

    // Fetch-unit / memory side
    modport slave (
        input  req_valid,
        input  rsp_ready,
        output req_ready,
        output rsp_valid
    );
endinterface
`default_nettype wire

// File: rtl/pc_ctrl_hazard_det.sv
`default_nettype none
// ============================================================================
// Module  : hazard_det
// Brief   : Load-use hazard detection between EX (load) and ID (sources).
// Revision: 1.0 - initial release
// ============================================================================
module hazard_det
    import pc_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  wire logic              i_idex_memrd,
    input  wire logic [REG_AW-1:0] i_idex_rd,
    input  wire logic [REG_AW-1:0] i_id_rs1,
    input  wire logic [REG_AW-1:0] i_id_rs2,
    input  wire logic              i_id_rs1_en,
    input  wire logic              i_id_rs2_en,
    output logic                   o_ld_use
);

    // x0 is never a real dependency; only enabled source reads count
    assign o_ld_use = i_idex_memrd & (i_idex_rd != '0) &
                      ((i_id_rs1_en & (i_idex_rd == i_id_rs1)) |
                       (i_id_rs2_en & (i_idex_rd == i_id_rs2)));

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_ctrl
// Brief   : Sequences the PC and pipeline front end: fetch handshakes,
//           redirects with stale-response discard, load-use / freeze stalls,
//           fetch watchdog and stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    pc_ctrl_if.master              ifu,
    input  wire logic              i_jump,
    input  wire logic              i_idex_memrd,
    input  wire logic [REG_AW-1:0] i_idex_rd,
    input  wire logic [REG_AW-1:0] i_id_rs1,
    input  wire logic [REG_AW-1:0] i_id_rs2,
    input  wire logic              i_id_rs1_en,
    input  wire logic              i_id_rs2_en,
    input  wire logic              i_exu_busy,
    output logic                   o_pcwen,
    output logic                   o_ifid_wen,
    output logic                   o_ifid_flush,
    output logic                   o_idex_wen,
    output logic                   o_idex_flush,
    output logic                   o_fetch_timeout,
    output logic [CNT_W-1:0]       o_stall_cnt
);

    localparam int              WD_W   = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    pc_ctrl_state_e   state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_ld_use, w_freeze, w_stall, w_jmp, w_deliver, w_waiting;

    hazard_det #(.REG_AW(REG_AW)) u_hazard_det (
        .i_idex_memrd (i_idex_memrd),
        .i_idex_rd    (i_idex_rd),
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_id_rs1_en  (i_id_rs1_en),
        .i_id_rs2_en  (i_id_rs2_en),
        .o_ld_use     (w_ld_use)
    );

    // A redirect is suppressed while its own ID operands are stalled
    assign w_freeze  = i_exu_busy;
    assign w_stall   = w_ld_use | w_freeze;
    assign w_jmp     = i_jump & ~w_stall;
    assign w_deliver = (state_q == S_WAIT) & ifu.rsp_valid & ~w_stall & ~w_jmp;
    assign w_waiting = (state_q == S_WAIT) | (state_q == S_DROP);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (ifu.req_ready) state_d = w_jmp ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (ifu.rsp_valid & (~w_stall | w_jmp)) state_d = S_REQ;
                else if (w_jmp)                         state_d = S_DROP;
            end
            S_DROP: if (ifu.rsp_valid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; enables are held low while reset is asserted
    always_comb begin
        ifu.req_valid = 1'b0;
        ifu.rsp_ready = 1'b0;
        o_pcwen       = 1'b0;
        o_ifid_wen    = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_wen    = 1'b0;
        o_idex_flush  = 1'b0;
        if (i_rst_n) begin
            ifu.req_valid = (state_q == S_REQ);
            ifu.rsp_ready = ((state_q == S_WAIT) & (~w_stall | w_jmp)) |
                            (state_q == S_DROP);
            o_pcwen       = w_jmp | w_deliver;
            o_ifid_wen    = w_deliver;
            o_ifid_flush  = w_jmp;
            o_idex_wen    = ~w_freeze;
            o_idex_flush  = w_ld_use & ~w_freeze;
        end
    end

    // Watchdog and stall counter next-state; watchdog saturates at TIMEOUT-1
    always_comb begin
        wd_d = '0;
        if (w_waiting & ~ifu.rsp_valid)
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        timeout_d   = timeout_q | (wd_d == WD_MAX);
        stall_cnt_d = stall_cnt_q;
        if (w_stall & (state_q != S_IDLE))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Watchdog, sticky timeout flag and stall counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_timeout = timeout_q;
    assign o_stall_cnt     = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_ctrl
// Brief   : Self-checking bench for pc_ctrl: directed corner sequences, a
//           hazard vector table and randomized traffic against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;
    localparam int TMO = 8;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       rst_n, req_ready, rsp_valid, jump, memrd, rs1_en, rs2_en, busy;
    logic [4:0] rd, rs1, rs2;
    logic       pcwen, ifid_wen, ifid_flush, idex_wen, idex_flush, tmo;
    logic [CW-1:0] stall_cnt;

    pc_ctrl_if ifu ();
    assign ifu.req_ready = req_ready;
    assign ifu.rsp_valid = rsp_valid;

    pc_ctrl #(.REG_AW(5), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .ifu(ifu), .i_jump(jump),
        .i_idex_memrd(memrd), .i_idex_rd(rd), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rs1_en(rs1_en), .i_id_rs2_en(rs2_en), .i_exu_busy(busy),
        .o_pcwen(pcwen), .o_ifid_wen(ifid_wen), .o_ifid_flush(ifid_flush),
        .o_idex_wen(idex_wen), .o_idex_flush(idex_flush),
        .o_fetch_timeout(tmo), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;

    // Reference model: front end described as "has started", "one fetch
    // outstanding" and "outstanding fetch is stale", plus plain counters.
    bit m_started, m_out, m_stale, m_tmo;
    int m_wd, m_cnt;
    bit e_rv, e_rr;
    // Memory responder (randomized phase only)
    bit auto_mem, mem_pending;
    int mem_lat;
    // Snapshot: {req_valid, rsp_ready, pcwen, ifid_wen, ifid_flush, idex_wen, idex_flush, timeout, cnt[7:0]}
    logic [15:0] snap;

    typedef struct {
        logic       memrd;
        logic [4:0] rd, rs1, rs2;
        logic       rs1_en, rs2_en, busy, jump;
        logic [4:0] exp;   // {pcwen, ifid_wen, ifid_flush, idex_wen, idex_flush}
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic clr_inputs();
        req_ready = 0; rsp_valid = 0; jump = 0; memrd = 0; rd = 0; rs1 = 0; rs2 = 0;
        rs1_en = 0; rs2_en = 0; busy = 0;
    endtask

    // One clock cycle: compare all outputs with the model, then advance both
    task automatic step();
        logic ld, frz, stl, jp, dl;
        logic [15:0] exp;
        if (auto_mem) rsp_valid = mem_pending && (mem_lat == 0);
        #1;
        ld  = memrd && (rd != 0) && ((rs1_en && rd == rs1) || (rs2_en && rd == rs2));
        frz = busy;
        stl = ld || frz;
        jp  = jump && !stl;
        if (!rst_n) begin
            m_started = 0; m_out = 0; m_stale = 0; m_wd = 0; m_tmo = 0; m_cnt = 0;
            e_rv = 0; e_rr = 0; exp = '0;
        end else begin
            e_rv = m_started && !m_out;
            e_rr = m_out && (m_stale || !stl || jp);
            dl   = m_out && !m_stale && rsp_valid && !stl && !jp;
            exp  = {e_rv, e_rr, jp || dl, dl, jp, !frz, ld && !frz, m_tmo, 8'(m_cnt)};
        end
        snap = {ifu.req_valid, ifu.rsp_ready, pcwen, ifid_wen, ifid_flush,
                idex_wen, idex_flush, tmo, stall_cnt};
        n_chk++;
        if (snap !== exp) begin
            n_err++;
            $display("FAIL model cycle %0d: got %h expected %h", cyc, snap, exp);
        end
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (m_started && stl) m_cnt = (m_cnt + 1) % 256;
            if (m_out && !rsp_valid) begin
                if (m_wd < TMO - 1) m_wd++;
            end else m_wd = 0;
            if (m_wd == TMO - 1) m_tmo = 1;
            if (!m_started) m_started = 1;
            else if (!m_out) begin
                if (req_ready) begin m_out = 1; m_stale = jp; end
            end else if (rsp_valid && e_rr) begin
                m_out = 0; m_stale = 0;
            end else if (jp) m_stale = 1;
            if (auto_mem) begin
                if (rsp_valid && e_rr) mem_pending = 0;
                else if (mem_pending && mem_lat > 0) mem_lat--;
                if (e_rv && req_ready) begin
                    mem_pending = 1; mem_lat = $urandom_range(0, 3);
                end
            end
        end else mem_pending = 0;
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};
        tbl[1] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10110};
        tbl[2] = '{1'b1, 5'd5,  5'd0,  5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011};
        tbl[3] = '{1'b1, 5'd5,  5'd5,  5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10110};
        tbl[4] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010};
        tbl[5] = '{1'b0, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
        tbl[6] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[7] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[8] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
        tbl[9] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011};

        auto_mem = 0; mem_pending = 0; mem_lat = 0;
        clr_inputs();
        rst_n = 0;
        #1;
        step();
        chk("reset_all_zero", int'(snap), 0);
        step();

        // Basic fetch: req in cycle 1, response one cycle after handshake
        rst_n = 1; req_ready = 1;
        step(); chk("idle_no_req", snap[15], 0);
        step(); chk("req_valid_c1", snap[15], 1);
        req_ready = 0;
        step(); chk("wait_no_pcwen", snap[13], 0);
        rsp_valid = 1;
        step(); chk("deliver_pcwen", snap[13], 1); chk("deliver_ifid_wen", snap[12], 1);
                chk("deliver_rsp_ready", snap[14], 1); chk("stall_cnt_zero", snap[7:0], 0);
        rsp_valid = 0;
        step(); chk("back_to_req", snap[15], 1);

        // Request not accepted for 5 cycles: valid held, PC untouched
        for (int i = 0; i < 5; i++) begin
            step(); chk("req_held", snap[15], 1); chk("req_held_pcwen", snap[13], 0);
        end
        req_ready = 1; step(); req_ready = 0;

        // Jump in WAIT, stale response 3 cycles later
        jump = 1;
        step(); chk("jmp_pcwen", snap[13], 1); chk("jmp_flush", snap[11], 1);
                chk("jmp_ifid_wen", snap[12], 0);
        jump = 0;
        for (int i = 0; i < 2; i++) begin
            step(); chk("drop_pcwen", snap[13], 0); chk("drop_rsp_ready", snap[14], 1);
        end
        rsp_valid = 1;
        step(); chk("stale_rsp_ready", snap[14], 1); chk("stale_ifid_wen", snap[12], 0);
                chk("stale_pcwen", snap[13], 0);
        rsp_valid = 0;
        step(); chk("new_req_after_drop", snap[15], 1);

        // Jump and response in the same cycle
        req_ready = 1; step(); req_ready = 0;
        jump = 1; rsp_valid = 1;
        step(); chk("jr_rsp_ready", snap[14], 1); chk("jr_ifid_wen", snap[12], 0);
                chk("jr_pcwen", snap[13], 1);
        jump = 0; rsp_valid = 0;
        step(); chk("jr_next_req", snap[15], 1);

        // Load-use with a jump while a response waits: everything held
        req_ready = 1; step(); req_ready = 0;
        begin
            int c0;
            c0 = int'(snap[7:0]);
            memrd = 1; rd = 5; rs2 = 5; rs2_en = 1; jump = 1; rsp_valid = 1;
            step(); chk("lu_pcwen", snap[13], 0); chk("lu_idex_flush", snap[9], 1);
                    chk("lu_ifid_wen", snap[12], 0); chk("lu_no_ifid_flush", snap[11], 0);
                    chk("lu_rsp_ready", snap[14], 0);
            memrd = 0; rd = 0; rs2 = 0; rs2_en = 0; jump = 0;
            step(); chk("lu_stall_cnt", int'(snap[7:0]), c0 + 1);
                    chk("lu_then_deliver", snap[12], 1);
            rsp_valid = 0;
        end

        // Hazard vector table, applied in S_REQ with no handshake
        for (int i = 0; i < 10; i++) begin
            memrd = tbl[i].memrd; rd = tbl[i].rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            rs1_en = tbl[i].rs1_en; rs2_en = tbl[i].rs2_en; busy = tbl[i].busy;
            jump = tbl[i].jump;
            step(); chk($sformatf("tbl%0d", i), int'(snap[13:9]), int'(tbl[i].exp));
        end
        clr_inputs();

        // Fetch timeout: no response ever arrives
        req_ready = 1; step(); req_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            step(); chk($sformatf("timeout_w%0d", i), snap[8], (i == 8) ? 1 : 0);
        end
        rsp_valid = 1; step(); rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("timeout_sticky", snap[8], 1);
        end
        req_ready = 1; step(); req_ready = 0;     // fetch in flight when reset hits
        rst_n = 0;
        step(); chk("rst_timeout_clr", snap[8], 0); chk("rst_cnt_clr", snap[7:0], 0);
        rst_n = 1;
        step(); chk("rst_idle", snap[15], 0);
        step(); chk("rst_req", snap[15], 1);

        // Randomized traffic with occasional resets
        auto_mem = 1;
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            req_ready = ($urandom_range(0, 9) < 7);
            jump      = ($urandom_range(0, 99) < 15);
            memrd     = ($urandom_range(0, 9) < 3);
            rd        = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rs1_en    = 1'($urandom_range(0, 1));
            rs2_en    = 1'($urandom_range(0, 1));
            busy      = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
